// File: rtl/text_cell_buffer.sv
// Character-cell screen memory for the HDMI terminal.
// Logical rows map onto a circular physical row store so that scrolling
// only blanks one row instead of copying the whole screen. One write port
// (parser side), one read port (pixel side), inferred block RAM.
module text_cell_buffer #(
  parameter int                DATA_W    = 7,
  parameter int                COLS      = 80,
  parameter int                ROWS      = 30,
  parameter logic [DATA_W-1:0] FILL      = 7'h20,
  parameter int                READ_PIPE = 0,
  parameter int                COL_W     = $clog2(COLS),
  parameter int                ROW_W     = $clog2(ROWS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [ROW_W-1:0]  wr_row,
  input  logic [COL_W-1:0]  wr_col,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              scroll_req,
  input  logic              clear_req,
  output logic              busy,
  output logic [ROW_W-1:0]  top_row,
  input  logic              rd_en,
  input  logic [ROW_W-1:0]  rd_row,
  input  logic [COL_W-1:0]  rd_col,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid
);

  localparam int CELLS  = ROWS * COLS;
  localparam int ADDR_W = $clog2(CELLS);

  localparam logic [ROW_W:0]      ROWS_V     = (ROW_W+1)'(ROWS);
  localparam logic [COL_W:0]      COLS_V     = (COL_W+1)'(COLS);
  localparam logic [ROW_W-1:0]    TOP_LAST   = ROW_W'(ROWS - 1);
  localparam logic [ADDR_W-1:0]   CELLS_LAST = ADDR_W'(CELLS - 1);
  localparam logic [ADDR_W-1:0]   ROW_LAST   = ADDR_W'(COLS - 1);
  localparam logic [ADDR_W-1:0]   COLS_A     = ADDR_W'(COLS);

  localparam logic [1:0] IDLE     = 2'd0;
  localparam logic [1:0] FILL_ROW = 2'd1;
  localparam logic [1:0] FILL_ALL = 2'd2;

  logic [1:0]        state;
  logic [ADDR_W-1:0] fill_cnt;
  logic [ROW_W-1:0]  r_clr;

  logic [DATA_W-1:0] mem [0:CELLS-1];

  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic              wr_in_range;
  logic              rd_in_range;
  logic [ADDR_W-1:0] wr_addr;
  logic [ADDR_W-1:0] rd_addr;
  logic [ADDR_W-1:0] row_base;

  logic              rd1_valid;
  logic [DATA_W-1:0] rd1_data;

  // Logical (row, col) to flat physical address, rotating by top.
  function automatic logic [ADDR_W-1:0] cell_addr(
    input logic [ROW_W-1:0] row,
    input logic [COL_W-1:0] col,
    input logic [ROW_W-1:0] top
  );
    logic [ROW_W:0] sum;
    sum = {1'b0, row} + {1'b0, top};
    if (sum >= ROWS_V) sum = sum - ROWS_V;
    return ADDR_W'(ADDR_W'(sum) * COLS_A + ADDR_W'(col));
  endfunction

  assign wr_ready    = (state == IDLE);
  assign busy        = !wr_ready;
  assign wr_in_range = ({1'b0, wr_row} < ROWS_V) && ({1'b0, wr_col} < COLS_V);
  assign rd_in_range = ({1'b0, rd_row} < ROWS_V) && ({1'b0, rd_col} < COLS_V);
  assign wr_addr     = cell_addr(wr_row, wr_col, top_row);
  assign rd_addr     = rd_in_range ? cell_addr(rd_row, rd_col, top_row) : '0;
  assign row_base    = ADDR_W'(ADDR_W'(r_clr) * COLS_A);

  // Control FSM: command acceptance in IDLE, fill sequencing otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= FILL_ALL;
      fill_cnt <= '0;
      top_row  <= '0;
      r_clr    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (clear_req) begin
            top_row  <= '0;
            fill_cnt <= '0;
            state    <= FILL_ALL;
          end else if (scroll_req) begin
            r_clr    <= top_row;
            top_row  <= (top_row == TOP_LAST) ? '0 : top_row + 1'b1;
            fill_cnt <= '0;
            state    <= FILL_ROW;
          end
        end
        FILL_ROW: begin
          if (fill_cnt == ROW_LAST) begin
            fill_cnt <= '0;
            state    <= IDLE;
          end else begin
            fill_cnt <= fill_cnt + 1'b1;
          end
        end
        FILL_ALL: begin
          if (fill_cnt == CELLS_LAST) begin
            fill_cnt <= '0;
            state    <= IDLE;
          end else begin
            fill_cnt <= fill_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Single array write port shared by client writes and fill sequencing.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = FILL;
    case (state)
      IDLE: begin
        mem_we    = wr_valid && wr_in_range;
        mem_waddr = wr_addr;
        mem_wdata = wr_data;
      end
      FILL_ROW: begin
        mem_we    = 1'b1;
        mem_waddr = row_base + fill_cnt;
      end
      FILL_ALL: begin
        mem_we    = 1'b1;
        mem_waddr = fill_cnt;
      end
      default: mem_we = 1'b0;
    endcase
  end

  // Array write; no reset so the array can map onto block RAM.
  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  // First read stage: out-of-range reads return the blank value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd1_valid <= 1'b0;
      rd1_data  <= '0;
    end else begin
      rd1_valid <= rd_en;
      if (rd_en) rd1_data <= rd_in_range ? mem[rd_addr] : FILL;
    end
  end

  generate
    if (READ_PIPE != 0) begin : g_pipe2
      // Optional output register; data holds when no result arrives.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          rd_valid <= 1'b0;
          rd_data  <= '0;
        end else begin
          rd_valid <= rd1_valid;
          if (rd1_valid) rd_data <= rd1_data;
        end
      end
    end else begin : g_pipe1
      assign rd_valid = rd1_valid;
      assign rd_data  = rd1_data;
    end
  endgenerate

endmodule

// File: tb/tb_text_cell_buffer.sv
// Directed bench for text_cell_buffer on a 4x3 screen, with one instance
// per read-pipeline setting sharing the same stimulus.
module tb_text_cell_buffer;

  localparam int DATA_W = 7;
  localparam int COLS   = 4;
  localparam int ROWS   = 3;
  localparam int COL_W  = 2;
  localparam int ROW_W  = 2;
  localparam logic [6:0] SP = 7'h20;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              wr_valid;
  logic [ROW_W-1:0]  wr_row;
  logic [COL_W-1:0]  wr_col;
  logic [DATA_W-1:0] wr_data;
  logic              scroll_req;
  logic              clear_req;
  logic              rd_en;
  logic [ROW_W-1:0]  rd_row;
  logic [COL_W-1:0]  rd_col;

  logic              wr_ready0, busy0, rd_valid0;
  logic [ROW_W-1:0]  top_row0;
  logic [DATA_W-1:0] rd_data0;
  logic              wr_ready1, busy1, rd_valid1;
  logic [ROW_W-1:0]  top_row1;
  logic [DATA_W-1:0] rd_data1;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  text_cell_buffer #(.DATA_W(DATA_W), .COLS(COLS), .ROWS(ROWS), .FILL(SP), .READ_PIPE(0)) dut0 (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready0), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
    .scroll_req(scroll_req), .clear_req(clear_req), .busy(busy0), .top_row(top_row0),
    .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data0), .rd_valid(rd_valid0)
  );

  text_cell_buffer #(.DATA_W(DATA_W), .COLS(COLS), .ROWS(ROWS), .FILL(SP), .READ_PIPE(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .wr_valid(wr_valid), .wr_ready(wr_ready1), .wr_row(wr_row), .wr_col(wr_col), .wr_data(wr_data),
    .scroll_req(scroll_req), .clear_req(clear_req), .busy(busy1), .top_row(top_row1),
    .rd_en(rd_en), .rd_row(rd_row), .rd_col(rd_col), .rd_data(rd_data1), .rd_valid(rd_valid1)
  );

  // Compare one observed value against its expected value.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of write/command inputs, then release them.
  task automatic applyStimulus(input logic wv, input int row, input int col, input logic [6:0] data,
                               input logic scroll, input logic clear);
    wr_valid   = wv;
    wr_row     = ROW_W'(row);
    wr_col     = COL_W'(col);
    wr_data    = data;
    scroll_req = scroll;
    clear_req  = clear;
    tick();
    wr_valid   = 1'b0;
    scroll_req = 1'b0;
    clear_req  = 1'b0;
  endtask

  // Count cycles until busy drops, bounded.
  task automatic waitIdle(input string tag, input int expected);
    int n = 0;
    while (busy0 && n < 100) begin
      tick();
      n++;
    end
    checkOutput(tag, n, expected);
    checkOutput({tag, "_rdy1"}, wr_ready1, 1);
  endtask

  // Single read observed on both latency variants.
  task automatic doRead(input string tag, input int row, input int col, input logic [6:0] expected);
    rd_en  = 1'b1;
    rd_row = ROW_W'(row);
    rd_col = COL_W'(col);
    tick();
    rd_en = 1'b0;
    checkOutput({tag, "_v0"}, rd_valid0, 1);
    checkOutput({tag, "_d0"}, rd_data0, expected);
    checkOutput({tag, "_v1early"}, rd_valid1, 0);
    tick();
    checkOutput({tag, "_v1"}, rd_valid1, 1);
    checkOutput({tag, "_d1"}, rd_data1, expected);
    checkOutput({tag, "_v0late"}, rd_valid0, 0);
  endtask

  // Fill logical rows 0..2 with 'A', 'B', 'C'.
  task automatic fillAbc();
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        applyStimulus(1'b1, r, c, 7'(7'h41 + r), 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; wr_valid = 1'b0; wr_row = '0; wr_col = '0; wr_data = '0;
    scroll_req = 1'b0; clear_req = 1'b0; rd_en = 1'b0; rd_row = '0; rd_col = '0;
    #23;
    checkOutput("rst_busy", busy0, 1);
    checkOutput("rst_ready", wr_ready0, 0);
    checkOutput("rst_top", top_row0, 0);
    checkOutput("rst_rdv", rd_valid0, 0);
    checkOutput("rst_rdd1", rd_data1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    waitIdle("init_fill", 12);
    checkOutput("init_top", top_row0, 0);
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        doRead("init_blank", r, c, SP);

    // Basic write/read round trip.
    applyStimulus(1'b1, 1, 2, 7'h41, 1'b0, 1'b0);
    doRead("wr_rd", 1, 2, 7'h41);

    // Back-to-back reads: one result per cycle on both variants.
    fillAbc();
    rd_en = 1'b1; rd_row = 2'd0; rd_col = 2'd0;
    tick();
    checkOutput("b2b_d0_a", rd_data0, 7'h41);
    rd_row = 2'd1;
    tick();
    checkOutput("b2b_d0_b", rd_data0, 7'h42);
    checkOutput("b2b_d1_a", rd_data1, 7'h41);
    rd_row = 2'd2;
    tick();
    rd_en = 1'b0;
    checkOutput("b2b_d0_c", rd_data0, 7'h43);
    checkOutput("b2b_d1_b", rd_data1, 7'h42);
    tick();
    checkOutput("b2b_v0_off", rd_valid0, 0);
    checkOutput("b2b_d0_hold", rd_data0, 7'h43);
    checkOutput("b2b_d1_c", rd_data1, 7'h43);
    tick();
    checkOutput("b2b_v1_off", rd_valid1, 0);

    // One scroll: rows shift up, bottom row blanked.
    applyStimulus(1'b0, 0, 0, 7'h00, 1'b1, 1'b0);
    checkOutput("scr_top", top_row0, 1);
    checkOutput("scr_busy", busy0, 1);
    waitIdle("scr_len", 4);
    doRead("scr_r0", 0, 0, 7'h42);
    doRead("scr_r1", 1, 3, 7'h43);
    doRead("scr_r2", 2, 1, SP);
    applyStimulus(1'b0, 0, 0, 7'h00, 1'b1, 1'b0);
    checkOutput("wrap_top2", top_row0, 2);
    waitIdle("wrap_len2", 4);
    applyStimulus(1'b0, 0, 0, 7'h00, 1'b1, 1'b0);
    checkOutput("wrap_top0", top_row0, 0);
    waitIdle("wrap_len0", 4);
    applyStimulus(1'b0, 0, 0, 7'h00, 1'b1, 1'b0);
    checkOutput("wrap_top1", top_row0, 1);
    waitIdle("wrap_len1", 4);

    // Out-of-range write/read with a rotated top row.
    fillAbc();
    applyStimulus(1'b1, 3, 0, 7'h5A, 1'b0, 1'b0);
    doRead("oor_wr", 0, 0, 7'h41);
    doRead("oor_rd", 3, 0, SP);

    // Write coinciding with scroll lands in the row being blanked.
    applyStimulus(1'b1, 0, 0, 7'h58, 1'b1, 1'b0);
    checkOutput("ws_top", top_row0, 2);
    checkOutput("ws_ready", wr_ready0, 0);
    waitIdle("ws_len", 4);
    doRead("ws_r0", 0, 0, 7'h42);
    doRead("ws_r2", 2, 0, SP);
    doRead("ws_r1", 1, 1, 7'h43);

    // Scroll during FILL_ROW is dropped.
    applyStimulus(1'b0, 0, 0, 7'h00, 1'b1, 1'b0);
    applyStimulus(1'b0, 0, 0, 7'h00, 1'b1, 1'b0);
    checkOutput("drop_top", top_row0, 0);
    waitIdle("drop_len", 3);
    checkOutput("drop_top_idle", top_row0, 0);
    doRead("drop_r0", 0, 2, 7'h43);

    // Clear beats simultaneous scroll.
    applyStimulus(1'b0, 0, 0, 7'h00, 1'b1, 1'b0);
    waitIdle("pre_clr", 4);
    checkOutput("pre_clr_top", top_row0, 1);
    applyStimulus(1'b0, 0, 0, 7'h00, 1'b1, 1'b1);
    checkOutput("clr_top", top_row0, 0);
    waitIdle("clr_len", 12);
    doRead("clr_r0", 0, 0, SP);
    doRead("clr_r2", 2, 3, SP);
    doRead("clr_oor", 3, 1, SP);

    // Reset pulsed in the middle of a full clear.
    rd_en = 1'b1; rd_row = 2'd0; rd_col = 2'd0;
    applyStimulus(1'b0, 0, 0, 7'h00, 1'b0, 1'b1);
    rd_en = 1'b0;
    tick();
    tick();
    checkOutput("mid_busy", busy0, 1);
    checkOutput("mid_rdd1", rd_data1, SP);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("mid_rst_busy", busy0, 1);
    checkOutput("mid_rst_ready", wr_ready1, 0);
    checkOutput("mid_rst_rdd0", rd_data0, 0);
    checkOutput("mid_rst_rdd1", rd_data1, 0);
    @(negedge clk);
    rst_n = 1'b1;
    waitIdle("mid_refill", 12);
    doRead("mid_after", 1, 1, SP);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL timeout: got running, expected finished");
    $fatal(1, "[TB] timeout");
  end

endmodule
